// File: rtl/ddr_pi_code_stepper.sv
// PI code stepper: walks the phase-interpolator code toward a requested
// target one LSB per step, along the shortest path around the code circle.
module ddr_pi_code_stepper #(
  parameter int          CWIDTH     = 6,
  parameter int          STEP_DLY   = 3,
  parameter int unsigned RESET_CODE = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_req,
  input  logic [CWIDTH-1:0] i_target,
  output logic              o_busy,
  output logic              o_done,
  output logic [CWIDTH-1:0] o_pi_code,
  output logic              o_pi_en
);

  localparam int DW = (STEP_DLY > 1) ? $clog2(STEP_DLY + 1) : 1;
  localparam logic [DW-1:0] DLY = DW'(STEP_DLY);
  localparam logic [CWIDTH-1:0] RST_C = CWIDTH'(RESET_CODE);
  localparam logic [CWIDTH-1:0] HALF =
    {1'b1, {(CWIDTH-1){1'b0}}};

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WALK = 1'b1;

  logic [0:0]        state;
  logic [CWIDTH-1:0] tgt;
  logic [DW-1:0]     cnt;
  logic              up;
  logic [CWIDTH-1:0] delta;
  logic              up_next;

  // Shortest-path direction; a half-circle tie goes upward.
  always_comb begin
    delta   = i_target - o_pi_code;
    up_next = (delta != '0) && (delta <= HALF);
  end

  // Walk FSM: abort on disable, finish on match, else step on dwell expiry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      o_pi_code <= RST_C;
      tgt       <= RST_C;
      cnt       <= '0;
      up        <= 1'b0;
      o_done    <= 1'b0;
      o_pi_en   <= 1'b0;
    end else begin
      o_pi_en <= i_en;
      o_done  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_en && i_req) begin
            tgt   <= i_target;
            up    <= up_next;
            cnt   <= DLY;
            state <= S_WALK;
          end
        end
        S_WALK: begin
          if (!i_en) begin
            state <= S_IDLE;
          end else if (o_pi_code == tgt) begin
            state  <= S_IDLE;
            o_done <= 1'b1;
          end else if (cnt == '0) begin
            o_pi_code <= up ? o_pi_code + 1'b1
                            : o_pi_code - 1'b1;
            cnt       <= DLY;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Busy simply mirrors the walk state.
  always_comb o_busy = (state == S_WALK);

endmodule
